// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the packet arbiter and the uart_drive user-TX port.
// master = arbiter side, slave = requesters plus the downstream transmitter.
interface uart_tx_arbiter_if #(
    parameter int P_REQ_NUM         = 4,
    parameter int P_UART_DATA_WIDTH = 8
);
    logic [P_REQ_NUM-1:0]                   req_valid;
    logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] req_data;
    logic [P_REQ_NUM-1:0]                   req_last;
    logic [P_REQ_NUM-1:0]                   req_ready;
    logic [P_UART_DATA_WIDTH-1:0]           tx_data;
    logic                                   tx_valid;
    logic                                   tx_ready;
    logic [P_REQ_NUM-1:0]                   grant;
    logic                                   busy;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant, busy
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one uart_drive user-TX channel between P_REQ_NUM requesters.
// A grant lasts one packet or P_MAX_BEATS words, followed by P_GAP_CYCLES idle cycles.
module uart_tx_arbiter #(
    parameter int P_REQ_NUM         = 4,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_MAX_BEATS       = 16,
    parameter int P_GAP_CYCLES      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int W  = P_UART_DATA_WIDTH;
    localparam int RW = $clog2(P_REQ_NUM);
    localparam int BW = $clog2(P_MAX_BEATS + 1);
    localparam int GW = (P_GAP_CYCLES > 1) ? $clog2(P_GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [P_REQ_NUM-1:0] grant_reg, grant_next;
    logic [RW-1:0]        owner_reg, owner_next;
    logic [RW-1:0]        rr_reg, rr_next;
    logic [BW-1:0]        beat_reg, beat_next;
    logic [GW-1:0]        gap_reg, gap_next;

    logic [W-1:0]         req_word [P_REQ_NUM];
    logic                 in_grant;
    logic                 tx_valid_int;
    logic                 transfer;
    logic                 release_now;
    logic [BW-1:0]        beat_inc;
    logic [RW-1:0]        pick_idx;

    for (genvar gi = 0; gi < P_REQ_NUM; gi++) begin : g_req
        assign req_word[gi] = bus.req_data[gi*W +: W];
    end

    // First requesting index strictly after ptr, wrapping modulo P_REQ_NUM.
    function automatic logic [RW-1:0] rr_pick(input logic [P_REQ_NUM-1:0] valid,
                                              input logic [RW-1:0]        ptr);
        logic [RW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= P_REQ_NUM; i++) begin
            idx = int'(ptr) + i;
            if (idx >= P_REQ_NUM) begin
                idx = idx - P_REQ_NUM;
            end
            if (!found && valid[idx[RW-1:0]]) begin
                found = 1'b1;
                pick  = idx[RW-1:0];
            end
        end
        return pick;
    endfunction

    assign in_grant     = (state_reg == GRANT);
    assign tx_valid_int = in_grant & bus.req_valid[owner_reg];
    assign transfer     = tx_valid_int & bus.tx_ready;
    assign beat_inc     = beat_reg + BW'(1);
    assign release_now  = transfer & (bus.req_last[owner_reg] | (beat_inc == BW'(P_MAX_BEATS)));
    assign pick_idx     = rr_pick(bus.req_valid, rr_reg);

    // Downstream path is purely combinational from the registered owner.
    assign bus.tx_valid  = tx_valid_int;
    assign bus.tx_data   = in_grant ? req_word[owner_reg] : '0;
    assign bus.req_ready = grant_reg & {P_REQ_NUM{bus.tx_ready}};
    assign bus.grant     = grant_reg;
    assign bus.busy      = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
            rr_reg    <= RW'(P_REQ_NUM - 1);
            beat_reg  <= '0;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            rr_reg    <= rr_next;
            beat_reg  <= beat_next;
            gap_reg   <= gap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        rr_next    = rr_reg;
        beat_next  = beat_reg;
        gap_next   = gap_reg;
        case (state_reg)
            IDLE: begin
                if (|bus.req_valid) begin
                    owner_next = pick_idx;
                    grant_next = {{(P_REQ_NUM-1){1'b0}}, 1'b1} << pick_idx;
                    beat_next  = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (transfer) begin
                    beat_next = beat_inc;
                end
                // A last word that also hits the beat limit still releases only once.
                if (release_now) begin
                    rr_next    = owner_reg;
                    beat_next  = '0;
                    grant_next = '0;
                    gap_next   = '0;
                    state_next = (P_GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_reg == GW'(P_GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a word-queue reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXB = 16;
    localparam int GAP  = 2;
    localparam int VW   = N + 1 + 1 + W + N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.P_REQ_NUM(N), .P_UART_DATA_WIDTH(W)) bus ();

    uart_tx_arbiter #(
        .P_REQ_NUM(N), .P_UART_DATA_WIDTH(W), .P_MAX_BEATS(MAXB), .P_GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Reference model: per-requester word queues {last, data} plus owner / pointer / gap bookkeeping.
    logic [8:0]   q [N][$];
    int           m_owner, m_rr, m_beats, m_gap;
    int           ready_pct, keep_pct;
    logic         hold_ready_low;
    logic [N-1:0] cur_valid, cur_last;
    logic [W-1:0] cur_data [N];
    logic         cur_ready;
    logic [VW-1:0] exp_vec, obs_vec;
    int           obs_log[$];
    int           checks, errors;

    function automatic int rr_next_owner(input logic [N-1:0] v, input int ptr);
        for (int i = 1; i <= N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) begin
            if (g[k]) return k;
        end
        return -1;
    endfunction

    function automatic bit model_active();
        for (int k = 0; k < N; k++) begin
            if (q[k].size() > 0) return 1'b1;
        end
        return (m_owner >= 0) || (m_gap > 0);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_ready = 1'b0;
        m_owner = -1; m_rr = N - 1; m_beats = 0; m_gap = 0;
        for (int k = 0; k < N; k++) q[k].delete();
        obs_log.delete();
        hold_ready_low = 1'b0; ready_pct = 100; keep_pct = 100;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (q[k].size() > 0) begin
                cur_valid[k] = (k == m_owner) ? ($urandom_range(99) < keep_pct) : 1'b1;
                cur_data[k]  = q[k][0][7:0];
                cur_last[k]  = q[k][0][8];
            end else begin
                cur_valid[k] = 1'b0;
                cur_data[k]  = W'($urandom);
                cur_last[k]  = 1'b0;
            end
            bus.req_data[k*W +: W] = cur_data[k];
        end
        cur_ready     = hold_ready_low ? 1'b0 : ($urandom_range(99) < ready_pct);
        bus.req_valid = cur_valid;
        bus.req_last  = cur_last;
        bus.tx_ready  = cur_ready;
    endtask

    // One clock: drive, predict, sample, then advance the model across the coming edge.
    task automatic step();
        logic [N-1:0] eg, er;
        logic         ev, eb;
        logic [W-1:0] ed;
        logic [8:0]   w;
        @(negedge clk);
        drive_inputs();
        #1;
        eg = '0; er = '0; ev = 1'b0; ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ev = cur_valid[m_owner];
            ed = cur_data[m_owner];
            er[m_owner] = cur_ready;
        end
        eb = (m_owner >= 0) || (m_gap > 0);
        exp_vec = {eg, eb, ev, ed, er};
        obs_vec = {bus.grant, bus.busy, bus.tx_valid, bus.tx_data, bus.req_ready};
        if (bus.tx_valid && bus.tx_ready) obs_log.push_back(onehot_idx(bus.grant) * 256 + int'(bus.tx_data));
        if (m_owner >= 0) begin
            if (cur_valid[m_owner] && cur_ready) begin
                w = q[m_owner].pop_front();
                m_beats++;
                if (w[8] || m_beats == MAXB) begin
                    m_rr = m_owner; m_owner = -1; m_beats = 0; m_gap = GAP;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (|cur_valid) begin
            m_owner = rr_next_owner(cur_valid, m_rr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1; bus.req_data = {N{8'h5A}}; bus.req_last = '1; bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.grant, bus.busy, bus.tx_valid, bus.tx_data, bus.req_ready} !== '0) begin
                errors++;
                $display("FAIL reset cycle %0d: outputs=%h expected=0", i,
                         {bus.grant, bus.busy, bus.tx_valid, bus.tx_data, bus.req_ready});
            end
        end
        do_reset();
    endtask

    task automatic test_single();
        int n = 0, gap_seen = 0;
        do_reset();
        q[1].push_back(9'h0A5);
        q[1].push_back(9'h13C);
        while (model_active() && n < 40) begin
            step(); n++; checks++;
            if (bus.busy && bus.grant == '0) gap_seen++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL single cycle %0d: outputs=%h expected=%h", n, obs_vec, exp_vec);
            end
        end
        checks++;
        if (model_active()) begin errors++; $display("FAIL single_timeout: active after %0d cycles, expected drained", n); end
        checks++;
        if (obs_log.size() != 2 || obs_log[0] != 256 + 'hA5 || obs_log[1] != 256 + 'h3C) begin
            errors++; $display("FAIL single_words: got %p, expected '{421, 316}", obs_log);
        end
        checks++;
        if (gap_seen != 2) begin errors++; $display("FAIL single_gap: got %0d gap cycles, expected 2", gap_seen); end
    endtask

    task automatic test_round_robin();
        int n = 0, gap_seen = 0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        q[0].push_back(9'h111);
        for (int k = 0; k < N; k++) q[k].push_back({1'b1, 8'(8'h20 + k)});
        while (model_active() && n < 80) begin
            step(); n++; checks++;
            if (bus.busy && bus.grant == '0) gap_seen++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL rr cycle %0d: outputs=%h expected=%h", n, obs_vec, exp_vec);
            end
        end
        checks++;
        if (obs_log.size() != 5) begin errors++; $display("FAIL rr_count: got %0d transfers, expected 5", obs_log.size()); end
        for (int i = 0; i < 5 && i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i] / 256 != exp_order[i]) begin
                errors++; $display("FAIL rr_order %0d: got owner %0d, expected %0d", i, obs_log[i] / 256, exp_order[i]);
            end
        end
        checks++;
        if (gap_seen != 5 * GAP) begin errors++; $display("FAIL rr_gap: got %0d gap cycles, expected %0d", gap_seen, 5 * GAP); end
    endtask

    task automatic test_max_beats();
        int n = 0;
        int exp_log[$];
        logic [7:0] d;
        do_reset();
        ready_pct = 70; keep_pct = 80;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom); q[0].push_back({(i == 19), d});
            if (i < 16) exp_log.push_back(int'(d));
        end
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom); q[2].push_back({(i == 2), d}); exp_log.push_back(512 + int'(d));
        end
        for (int i = 16; i < 20; i++) exp_log.push_back(int'(q[0][i][7:0]));
        while (model_active() && n < 400) begin
            step(); n++; checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL maxbeats cycle %0d: outputs=%h expected=%h", n, obs_vec, exp_vec);
            end
        end
        checks++;
        if (obs_log.size() != exp_log.size()) begin
            errors++; $display("FAIL maxbeats_count: got %0d, expected %0d", obs_log.size(), exp_log.size());
        end
        for (int i = 0; i < exp_log.size() && i < obs_log.size(); i++) begin
            checks++;
            if (obs_log[i] != exp_log[i]) begin
                errors++; $display("FAIL maxbeats_word %0d: got %h, expected %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int exp_log[$];
        logic [7:0] d, w3;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            d = 8'($urandom); q[1].push_back({(i == 17), d});
            if (i < 16) exp_log.push_back(256 + int'(d));
        end
        q[3].push_back(9'h1C3);
        exp_log.push_back(768 + 'hC3);
        exp_log.push_back(256 + int'(q[1][16][7:0]));
        exp_log.push_back(256 + int'(q[1][17][7:0]));
        w3 = q[1][2][7:0];
        while (obs_log.size() < 2 && n < 20) begin
            step(); n++; checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL bp_lead cycle %0d: outputs=%h expected=%h", n, obs_vec, exp_vec);
            end
        end
        hold_ready_low = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(); checks++;
            if (obs_vec !== exp_vec || bus.tx_valid !== 1'b1 || bus.tx_data !== w3 || bus.req_ready !== '0) begin
                errors++; $display("FAIL bp_hold cycle %0d: valid=%b data=%h ready=%b, expected valid=1 data=%h ready=0",
                                   i, bus.tx_valid, bus.tx_data, bus.req_ready, w3);
            end
        end
        hold_ready_low = 1'b0;
        n = 0;
        while (model_active() && n < 200) begin
            step(); n++; checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL bp_tail cycle %0d: outputs=%h expected=%h", n, obs_vec, exp_vec);
            end
        end
        checks++;
        if (obs_log != exp_log) begin errors++; $display("FAIL bp_words: got %p, expected %p", obs_log, exp_log); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        logic [7:0] w3;
        do_reset();
        for (int i = 0; i < 5; i++) q[2].push_back({(i == 4), 8'($urandom)});
        w3 = q[2][2][7:0];
        while (obs_log.size() < 2 && n < 20) begin
            step(); n++; checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL areset_lead cycle %0d: outputs=%h expected=%h", n, obs_vec, exp_vec);
            end
        end
        q[0].push_back(9'h1EE);
        @(negedge clk);
        drive_inputs();
        #1;
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== w3 || bus.grant !== 4'b0100) begin
            errors++; $display("FAIL areset_third: valid=%b data=%h grant=%b, expected 1 %h 0100",
                               bus.tx_valid, bus.tx_data, bus.grant, w3);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.grant, bus.busy, bus.tx_valid, bus.tx_data, bus.req_ready} !== '0) begin
            errors++; $display("FAIL areset_clear: outputs=%h expected=0",
                               {bus.grant, bus.busy, bus.tx_valid, bus.tx_data, bus.req_ready});
        end
        do_reset();
        q[2].push_back(9'h0AA); q[2].push_back(9'h1BB);
        q[0].push_back(9'h1CC);
        n = 0;
        while (model_active() && n < 60) begin
            step(); n++; checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL areset_after cycle %0d: outputs=%h expected=%h", n, obs_vec, exp_vec);
            end
        end
        checks++;
        if (obs_log.size() == 0 || obs_log[0] != 'hCC) begin
            errors++; $display("FAIL areset_first_owner: got %p, expected first word from requester 0 (cc)", obs_log);
        end
    endtask

    task automatic test_random();
        int n = 0, len, j;
        int streams [N][$];
        logic [7:0] d;
        do_reset();
        ready_pct = 60; keep_pct = 70;
        for (int k = 0; k < N; k++) begin
            for (int p = 0; p < 2; p++) begin
                len = $urandom_range(20, 1);
                for (int i = 0; i < len; i++) begin
                    d = 8'($urandom); q[k].push_back({(i == len - 1), d}); streams[k].push_back(k * 256 + int'(d));
                end
            end
        end
        while (model_active() && n < 3000) begin
            step(); n++; checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL random cycle %0d: outputs=%h expected=%h", n, obs_vec, exp_vec);
            end
        end
        checks++;
        if (model_active()) begin errors++; $display("FAIL random_timeout: active after %0d cycles, expected drained", n); end
        for (int k = 0; k < N; k++) begin
            j = 0;
            foreach (obs_log[i]) begin
                if (obs_log[i] / 256 == k) begin
                    checks++;
                    if (j >= streams[k].size() || obs_log[i] != streams[k][j]) begin
                        errors++; $display("FAIL random_stream req%0d word %0d: got %h, expected %h", k, j, obs_log[i],
                                           (j < streams[k].size()) ? streams[k][j] : -1);
                    end
                    j++;
                end
            end
            checks++;
            if (j != streams[k].size()) begin
                errors++; $display("FAIL random_stream_len req%0d: got %0d words, expected %0d", k, j, streams[k].size());
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_owner = -1; m_rr = N - 1; m_beats = 0; m_gap = 0;
        hold_ready_low = 1'b0; ready_pct = 100; keep_pct = 100;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_max_beats();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
